// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size masks,
// FSM state encodings, default base address and a byte-mask expander.
package dmem_responder_pkg;

  localparam logic [7:0]  MEM_MASK_8     = 8'h01;
  localparam logic [7:0]  MEM_MASK_16    = 8'h03;
  localparam logic [7:0]  MEM_MASK_32    = 8'h0F;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;

  localparam int unsigned DMEM_CNT_W     = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Expand a 4-bit byte mask to a 32-bit bit mask.
  function automatic logic [31:0] mask_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: DEPTH x 32 bits, synchronous byte-enabled
// write, combinational read of the addressed word.
// Ports: clk; we/be/addr/wdata write side; rdata combinational read data.
module dmem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; bytes not enabled keep their content.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU: one request at a time on a valid/ready
// request channel, LATENCY wait cycles, then a held response on a valid/ready
// response channel. Checks range, alignment and mask legality.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_wen/req_addr/
//        req_wdata/req_mask request channel; rsp_valid/rsp_ready/rsp_rdata/
//        rsp_err response channel.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned          ADDR_LEN  = 32,
  parameter int unsigned          DATA_LEN  = 32,
  parameter int unsigned          DEPTH     = 1024,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR = ADDR_LEN'(DMEM_BASE_ADDR),
  parameter int unsigned          LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [7:0]          req_mask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned WIDX_W = ADDR_LEN - 2;

  dmem_state_e             state_q, state_d;
  logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    accept, exec;

  logic                    wen_q;
  logic [ADDR_LEN-1:0]     addr_q;
  logic [DATA_LEN-1:0]     wdata_q;
  logic [7:0]              mask_q;

  logic                    e_wen;
  logic [ADDR_LEN-1:0]     e_addr;
  logic [DATA_LEN-1:0]     e_wdata;
  logic [7:0]              e_mask;

  logic [ADDR_LEN-1:0]     off;
  logic [1:0]              lane;
  logic [WIDX_W-1:0]       widx;
  logic                    oor, misal, illegal, err_c;
  logic [3:0]              be;
  logic [DATA_LEN-1:0]     wshift, word, rdata_c;
  logic                    mem_we;

  // Next-state logic; exec marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    exec    = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = DMEM_RESP;
            exec    = 1'b1;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = DMEM_CNT_W'(LATENCY - 1);
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_RESP;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      DMEM_RESP: begin
        if (rsp_ready) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // With zero latency the access executes on the accept edge, before the
  // request latches are loaded, so the live request is used instead.
  always_comb begin
    if (state_q == DMEM_IDLE) begin
      e_wen   = req_wen;
      e_addr  = req_addr;
      e_wdata = req_wdata;
      e_mask  = req_mask;
    end else begin
      e_wen   = wen_q;
      e_addr  = addr_q;
      e_wdata = wdata_q;
      e_mask  = mask_q;
    end
  end

  // Address decode and error classification.
  always_comb begin
    off     = e_addr - BASE_ADDR;
    lane    = off[1:0];
    widx    = off[ADDR_LEN-1:2];
    oor     = (e_addr < BASE_ADDR) || (widx >= WIDX_W'(DEPTH));
    misal   = 1'b0;
    illegal = 1'b0;
    unique case (e_mask)
      MEM_MASK_8:  misal = 1'b0;
      MEM_MASK_16: misal = lane[0];
      MEM_MASK_32: misal = (lane != 2'd0);
      default:     illegal = 1'b1;
    endcase
    err_c   = oor | misal | illegal;
    be      = e_mask[3:0] << lane;
    wshift  = e_wdata << {lane, 3'b000};
    rdata_c = (word >> {lane, 3'b000}) & DATA_LEN'(mask_bits(e_mask[3:0]));
  end

  // A commit edge that coincides with reset must not write.
  assign mem_we = exec && e_wen && !err_c && !rst;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be),
    .addr  (widx[AW-1:0]),
    .wdata (wshift),
    .rdata (word)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DMEM_IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == DMEM_IDLE);
      rsp_valid <= (state_d == DMEM_RESP);
      if (exec) begin
        rsp_err   <= err_c;
        rsp_rdata <= (err_c || e_wen) ? '0 : rdata_c;
      end
    end
  end

  // Request capture; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      mask_q  <= req_mask;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one
// LATENCY=0 instance sharing the request inputs, selected by sel.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_wen, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_mask;

  logic        rr2, rv2, re2, rr0, rv0, re0;
  logic [31:0] rd2, rd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rr2), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rv2), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rr0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd0), .rsp_err(re0)
  );

  assign req_ready = sel ? rr0 : rr2;
  assign rsp_valid = sel ? rv0 : rv2;
  assign rsp_rdata = sel ? rd0 : rd2;
  assign rsp_err   = sel ? re0 : re2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; now=1 presents the request at the current negedge.
  task automatic txn(input string tag, input bit now, input logic wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] mask, input int exp_lat, input int bp,
                     output logic [31:0] rd, output logic er);
    int  n;
    int  lat;
    logic held;
    if (!now) @(negedge clk);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_mask = mask;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    rd = rsp_rdata;
    er = rsp_err;
    held = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || req_ready !== 1'b0) held = 1'b0;
    end
    if (bp > 0) check({tag, "_held"}, 32'(held), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        seen;
  logic [31:0] bdata [4];
  int          acc_cyc [4];
  int          cyc, k_acc, k_rsp;

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata",     rsp_rdata,       32'd0);
    check("reset_err",       32'(rsp_err),    32'd0);
    rst = 1'b0;

    // Word round trip
    txn("st_word", 0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 3, 0, rd, er);
    check("st_word_err", 32'(er), 32'd0);
    check("st_word_rdata", rd, 32'd0);
    txn("ld_word", 0, 0, 32'h8000_0010, 32'h0, 8'h0F, 3, 0, rd, er);
    check("ld_word_rdata", rd, 32'hDEAD_BEEF);
    check("ld_word_err", 32'(er), 32'd0);

    // Byte and half lanes
    txn("st_byte", 0, 1, 32'h8000_0013, 32'h0000_00AB, 8'h01, 3, 0, rd, er);
    check("st_byte_err", 32'(er), 32'd0);
    txn("ld_after_byte", 0, 0, 32'h8000_0010, 32'h0, 8'h0F, 3, 0, rd, er);
    check("ld_after_byte_rdata", rd, 32'hABAD_BEEF);
    txn("ld_half", 0, 0, 32'h8000_0012, 32'h0, 8'h03, 3, 0, rd, er);
    check("ld_half_rdata", rd, 32'h0000_ABAD);
    check("ld_half_err", 32'(er), 32'd0);

    // Errors; none of these may write
    txn("st_half_mis", 0, 1, 32'h8000_0011, 32'h0000_FFFF, 8'h03, 3, 0, rd, er);
    check("st_half_mis_err", 32'(er), 32'd1);
    txn("ld_word_mis", 0, 0, 32'h8000_0002, 32'h0, 8'h0F, 3, 0, rd, er);
    check("ld_word_mis_err", 32'(er), 32'd1);
    check("ld_word_mis_rdata", rd, 32'd0);
    txn("ld_below", 0, 0, 32'h7FFF_FFFC, 32'h0, 8'h0F, 3, 0, rd, er);
    check("ld_below_err", 32'(er), 32'd1);
    txn("ld_above", 0, 0, 32'h8000_1000, 32'h0, 8'h0F, 3, 0, rd, er);
    check("ld_above_err", 32'(er), 32'd1);
    txn("st_bad_mask", 0, 1, 32'h8000_0010, 32'h0000_0000, 8'h07, 3, 0, rd, er);
    check("st_bad_mask_err", 32'(er), 32'd1);
    txn("reload", 0, 0, 32'h8000_0010, 32'h0, 8'h0F, 3, 0, rd, er);
    check("reload_rdata", rd, 32'hABAD_BEEF);

    // Response backpressure, then immediate next accept
    txn("bp", 0, 0, 32'h8000_0010, 32'h0, 8'h0F, 3, 5, rd, er);
    check("bp_rdata", rd, 32'hABAD_BEEF);
    check("bp_ready_after", 32'(req_ready), 32'd1);
    txn("bp_next", 1, 0, 32'h8000_0012, 32'h0, 8'h03, 3, 0, rd, er);
    check("bp_next_rdata", rd, 32'h0000_ABAD);

    // Reset during WAIT of a store
    txn("st_old", 0, 1, 32'h8000_0020, 32'h0BAD_F00D, 8'h0F, 3, 0, rd, er);
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678;
    req_mask = 8'h0F; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_in_wait_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", 32'(seen), 32'd0);
    txn("ld_old", 0, 0, 32'h8000_0020, 32'h0, 8'h0F, 3, 0, rd, er);
    check("ld_old_rdata", rd, 32'h0BAD_F00D);

    // LATENCY=0 instance: preload, then back-to-back loads
    @(negedge clk);
    sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bdata[k] = 32'hC0DE_0000 | 32'(k * 17);
      txn("l0_st", 0, 1, 32'h8000_0040 + 32'(4 * k), bdata[k], 8'h0F, 1, 0, rd, er);
    end
    @(negedge clk);
    rsp_ready = 1'b1; req_wen = 1'b0; req_mask = 8'h0F;
    cyc = 0; k_acc = 0; k_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid && k_rsp < 4) begin
        check("b2b_rdata", rsp_rdata, bdata[k_rsp]);
        check("b2b_lat", 32'(cyc - acc_cyc[k_rsp]), 32'd1);
        k_rsp++;
      end
      if (req_ready) begin
        if (k_acc < 4) begin
          req_addr  = 32'h8000_0040 + 32'(4 * k_acc);
          req_valid = 1'b1;
          acc_cyc[k_acc] = cyc;
          k_acc++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_count", 32'(k_rsp), 32'd4);
    for (int k = 1; k < 4; k++) check("b2b_period", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
